vlc_packer: RTL and testbench

Parametrised successor to the 1-bit serial VLC stream path. It accepts variable-length codewords of up to MAX_LEN bits per beat and packs them MSB-first into OUT_W-bit words. Partial words are emitted on an explicit flush. It sits between the VLC code generator and the word-oriented output buffer, with valid/ready handshakes on both sides.

---
 rtl/vlc_packer_if.sv | 37 +++
 rtl/vlc_packer.sv | 110 +++++++++++
 tb/tb_vlc_packer.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vlc_packer_if.sv
// Bus bundle for vlc_packer: codeword input side, packed-word output side,
// plus status and debug visibility of the packer's internal state.
//
// Handshake rule for both din and dout: a transfer happens at a rising clk
// edge where valid and ready are both high. The source holds its payload
// stable while valid is high and ready is low; ready may change freely.
interface vlc_packer_if #(
  parameter int MAX_LEN = 16,
  parameter int OUT_W   = 32
);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int BW = $clog2(OUT_W + 1);
  localparam int CW = $clog2(OUT_W + MAX_LEN + 1);

  logic [MAX_LEN-1:0] code_in;
  logic [LW-1:0]      len_in;
  logic               din_valid;
  logic               din_ready;
  logic               flush;
  logic [OUT_W-1:0]   data_out;
  logic               dout_valid;
  logic               dout_ready;
  logic [BW-1:0]      dout_bits;
  logic               busy;
  logic               dbg_state;  // 0 = RUN, 1 = FLUSH
  logic [CW-1:0]      dbg_cnt;    // accumulator fill count

  modport master (
    output code_in, len_in, din_valid, flush, dout_ready,
    input  din_ready, data_out, dout_valid, dout_bits, busy, dbg_state, dbg_cnt
  );

  modport slave (
    input  code_in, len_in, din_valid, flush, dout_ready,
    output din_ready, data_out, dout_valid, dout_bits, busy, dbg_state, dbg_cnt
  );
endinterface

// File: rtl/vlc_packer.sv
// Variable-length codeword packer. Codewords of up to MAX_LEN bits are
// appended MSB-first into a left-aligned accumulator and drained as OUT_W-bit
// words; a flush drains the residual partial word, zero padded.
module vlc_packer #(
  parameter int MAX_LEN = 16,
  parameter int OUT_W   = 32
) (
  input logic         clk,
  input logic         rst,
  vlc_packer_if.slave bus
);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int BW = $clog2(OUT_W + 1);
  localparam int CW = $clog2(OUT_W + MAX_LEN + 1);
  localparam int AW = OUT_W + MAX_LEN;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t             state;
  logic [AW-1:0]      acc;
  logic [CW-1:0]      cnt;
  logic [OUT_W-1:0]   data_q;
  logic [BW-1:0]      bits_q;
  logic               valid_q;

  logic [LW-1:0]      l_eff;
  logic [MAX_LEN-1:0] code_masked;
  logic [MAX_LEN-1:0] code_left;
  logic [AW-1:0]      append_vec;
  logic [OUT_W-1:0]   keep_mask;
  logic               out_free;
  logic               word_ready;
  logic               din_ready_int;
  logic               take_in;

  // Clamp the length, strip unused code bits and position the code right
  // after the cnt bits already held; decode handshake and emission conditions.
  always_comb begin
    l_eff         = (bus.len_in > LW'(MAX_LEN)) ? LW'(MAX_LEN) : bus.len_in;
    code_masked   = bus.code_in & ~({MAX_LEN{1'b1}} << l_eff);
    code_left     = code_masked << (LW'(MAX_LEN) - l_eff);
    append_vec    = {code_left, {OUT_W{1'b0}}} >> cnt;
    keep_mask     = ~({OUT_W{1'b1}} >> cnt);
    out_free      = !valid_q || bus.dout_ready;
    word_ready    = (cnt >= CW'(OUT_W));
    // Gated by rst so din_ready reads 0 while reset is held.
    din_ready_int = rst && (state == RUN) && !word_ready;
    take_in       = bus.din_valid && din_ready_int;
  end

  // Accumulator, output register and RUN/FLUSH control. Append, full-word
  // emission and partial-word flush never coincide: appends only happen with
  // cnt < OUT_W in RUN, full words need cnt >= OUT_W, partials need FLUSH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= RUN;
      acc     <= '0;
      cnt     <= '0;
      data_q  <= '0;
      bits_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      if (valid_q && bus.dout_ready) begin
        valid_q <= 1'b0;
      end

      if (take_in) begin
        acc <= acc | append_vec;
        cnt <= cnt + CW'(l_eff);
      end else if (word_ready && out_free) begin
        data_q  <= acc[AW-1 -: OUT_W];
        bits_q  <= BW'(OUT_W);
        valid_q <= 1'b1;
        acc     <= acc << OUT_W;
        cnt     <= cnt - CW'(OUT_W);
      end else if ((state == FLUSH) && out_free) begin
        if (cnt != '0) begin
          data_q  <= acc[AW-1 -: OUT_W] & keep_mask;
          bits_q  <= BW'(cnt);
          valid_q <= 1'b1;
        end
        acc <= '0;
        cnt <= '0;
      end

      case (state)
        RUN: begin
          if (bus.flush) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          // A second flush request here is simply not looked at.
          if (!word_ready && out_free) begin
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign bus.din_ready  = din_ready_int;
  assign bus.data_out   = data_q;
  assign bus.dout_bits  = bits_q;
  assign bus.dout_valid = valid_q;
  assign bus.busy       = (cnt != '0) || valid_q || (state == FLUSH);
  assign bus.dbg_state  = (state == FLUSH);
  assign bus.dbg_cnt    = cnt;
endmodule

// File: tb/tb_vlc_packer.sv
// Bench for vlc_packer with OUT_W=8, MAX_LEN=4: directed scenarios plus a
// randomized run, all output words checked against a bit-queue model.
module tb_vlc_packer;
  localparam int MAX_LEN = 4;
  localparam int OUT_W   = 8;
  localparam int BW      = $clog2(OUT_W + 1);
  localparam int W       = OUT_W + BW;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  vlc_packer_if #(.MAX_LEN(MAX_LEN), .OUT_W(OUT_W)) bus ();

  vlc_packer #(.MAX_LEN(MAX_LEN), .OUT_W(OUT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Bits in stream order; every OUT_W of them form a word, a flush pads the rest.
  logic         bit_q[$];
  logic [W-1:0] exp_q[$];

  function automatic void model_push(input logic [MAX_LEN-1:0] code, input int len);
    int l;
    logic [OUT_W-1:0] w;
    l = (len > MAX_LEN) ? MAX_LEN : len;
    for (int i = l - 1; i >= 0; i--) bit_q.push_back(code[i]);
    while (bit_q.size() >= OUT_W) begin
      for (int i = 0; i < OUT_W; i++) w[OUT_W-1-i] = bit_q.pop_front();
      exp_q.push_back({w, BW'(OUT_W)});
    end
  endfunction

  function automatic void model_flush();
    int n;
    logic [OUT_W-1:0] w;
    n = bit_q.size();
    w = '0;
    if (n > 0) begin
      for (int i = 0; i < n; i++) w[OUT_W-1-i] = bit_q.pop_front();
      exp_q.push_back({w, BW'(n)});
    end
  endfunction

  // Scoreboard: inputs are stable at negedge, so what is seen here is what
  // the next posedge acts on.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.dout_valid && bus.dout_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL sb_unexpected: got data=%h bits=%0d, want no word", bus.data_out, bus.dout_bits);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          if ({bus.data_out, bus.dout_bits} !== e) begin
            miscompares++;
            $display("FAIL sb_word: got data=%h bits=%0d, want data=%h bits=%0d",
                     bus.data_out, bus.dout_bits, e[W-1 -: OUT_W], e[BW-1:0]);
          end
        end
      end
      if (bus.din_valid && bus.din_ready) model_push(bus.code_in, int'(bus.len_in));
      if (bus.flush) model_flush();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [MAX_LEN-1:0] code, input logic [2:0] len);
    int t;
    t = 0;
    bus.code_in   = code;
    bus.len_in    = len;
    bus.din_valid = 1'b1;
    @(negedge clk);
    while (!bus.din_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.din_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL din_timeout: got din_ready=0 after %0d cycles, want 1", t);
    end
    @(posedge clk);
    #1;
    bus.din_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    #3;
    vectors++; if (bus.dout_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b want 0", bus.dout_valid); end
    vectors++; if (bus.data_out !== 8'h00) begin miscompares++; $display("FAIL rst_data: got %h want 00", bus.data_out); end
    vectors++; if (bus.din_ready !== 1'b0) begin miscompares++; $display("FAIL rst_din_ready: got %b want 0", bus.din_ready); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    #10 rst = 1'b1;
    #1;
    vectors++; if (bus.din_ready !== 1'b1) begin miscompares++; $display("FAIL rel_din_ready: got %b want 1", bus.din_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_exact_fill();
    bus.dout_ready = 1'b1;
    send(4'b0101, 3'd3);
    send(4'b0011, 3'd4);
    send(4'b0001, 3'd1);
    vectors++; if (bus.din_ready !== 1'b0) begin miscompares++; $display("FAIL fill_full_ready: got %b want 0", bus.din_ready); end
    vectors++; if (bus.dbg_cnt !== 4'd8) begin miscompares++; $display("FAIL fill_cnt8: got %0d want 8", bus.dbg_cnt); end
    tick(1);
    vectors++; if (bus.dout_valid !== 1'b1) begin miscompares++; $display("FAIL fill_valid: got %b want 1", bus.dout_valid); end
    vectors++; if (bus.data_out !== 8'hA7) begin miscompares++; $display("FAIL fill_data: got %h want a7", bus.data_out); end
    vectors++; if (bus.dout_bits !== 4'd8) begin miscompares++; $display("FAIL fill_bits: got %0d want 8", bus.dout_bits); end
    vectors++; if (bus.dbg_cnt !== 4'd0) begin miscompares++; $display("FAIL fill_cnt0: got %0d want 0", bus.dbg_cnt); end
    tick(1);
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL fill_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_straddle_flush();
    send(4'b0110, 3'd3);
    send(4'b0001, 3'd3);
    send(4'b1011, 3'd4);
    tick(1);
    vectors++; if (bus.data_out !== 8'hC6) begin miscompares++; $display("FAIL strad_data: got %h want c6", bus.data_out); end
    vectors++; if (bus.dbg_cnt !== 4'd2) begin miscompares++; $display("FAIL strad_cnt: got %0d want 2", bus.dbg_cnt); end
    tick(1);
    pulse_flush();
    vectors++; if (bus.dbg_state !== 1'b1) begin miscompares++; $display("FAIL strad_state_flush: got %b want 1", bus.dbg_state); end
    tick(1);
    vectors++; if (bus.dout_valid !== 1'b1) begin miscompares++; $display("FAIL strad_pvalid: got %b want 1", bus.dout_valid); end
    vectors++; if (bus.data_out !== 8'hC0) begin miscompares++; $display("FAIL strad_pdata: got %h want c0", bus.data_out); end
    vectors++; if (bus.dout_bits !== 4'd2) begin miscompares++; $display("FAIL strad_pbits: got %0d want 2", bus.dout_bits); end
    vectors++; if (bus.dbg_state !== 1'b0) begin miscompares++; $display("FAIL strad_state_run: got %b want 0", bus.dbg_state); end
    tick(1);
  endtask

  task automatic test_backpressure();
    bus.dout_ready = 1'b0;
    send(4'hA, 3'd4);
    send(4'h5, 3'd4);
    tick(1);
    send(4'h3, 3'd4);
    send(4'hC, 3'd4);
    vectors++; if (bus.din_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready_low: got %b want 0", bus.din_ready); end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (bus.dout_valid !== 1'b1 || bus.data_out !== 8'hA5 || bus.din_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: got valid=%b data=%h ready=%b want 1/a5/0", i, bus.dout_valid, bus.data_out, bus.din_ready);
      end
      tick(1);
    end
    bus.dout_ready = 1'b1;
    tick(1);
    vectors++; if (bus.data_out !== 8'h3C || bus.dout_valid !== 1'b1) begin miscompares++; $display("FAIL bp_second: got valid=%b data=%h want 1/3c", bus.dout_valid, bus.data_out); end
    vectors++; if (bus.din_ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready_back: got %b want 1", bus.din_ready); end
    tick(1);
    vectors++; if (bus.dout_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drained: got %b want 0", bus.dout_valid); end
  endtask

  task automatic test_flush_empty();
    pulse_flush();
    vectors++; if (bus.din_ready !== 1'b0 || bus.dout_valid !== 1'b0) begin miscompares++; $display("FAIL fe_during: got ready=%b valid=%b want 0/0", bus.din_ready, bus.dout_valid); end
    tick(1);
    vectors++; if (bus.din_ready !== 1'b1 || bus.dout_valid !== 1'b0) begin miscompares++; $display("FAIL fe_after: got ready=%b valid=%b want 1/0", bus.din_ready, bus.dout_valid); end
    bus.code_in   = 4'b0011;
    bus.len_in    = 3'd2;
    bus.din_valid = 1'b1;
    bus.flush     = 1'b1;
    @(posedge clk);
    #1;
    bus.din_valid = 1'b0;
    bus.flush     = 1'b0;
    vectors++; if (bus.dbg_state !== 1'b1) begin miscompares++; $display("FAIL fe_sim_state: got %b want 1", bus.dbg_state); end
    tick(1);
    vectors++; if (bus.data_out !== 8'hC0 || bus.dout_bits !== 4'd2 || bus.dout_valid !== 1'b1) begin miscompares++; $display("FAIL fe_sim_word: got valid=%b data=%h bits=%0d want 1/c0/2", bus.dout_valid, bus.data_out, bus.dout_bits); end
    tick(1);
  endtask

  task automatic test_len_edges();
    send(4'hF, 3'd0);
    vectors++; if (bus.dbg_cnt !== 4'd0 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL len0: got cnt=%0d busy=%b want 0/0", bus.dbg_cnt, bus.busy); end
    send(4'b1001, 3'd7);
    vectors++; if (bus.dbg_cnt !== 4'd4) begin miscompares++; $display("FAIL len7_cnt: got %0d want 4", bus.dbg_cnt); end
    send(4'b0110, 3'd4);
    tick(1);
    vectors++; if (bus.data_out !== 8'h96) begin miscompares++; $display("FAIL len7_word: got %h want 96", bus.data_out); end
    tick(1);
  endtask

  task automatic test_reset_mid();
    bus.dout_ready = 1'b0;
    send(4'hA, 3'd4);
    send(4'h5, 3'd4);
    tick(1);
    send(4'hF, 3'd4);
    send(4'h1, 3'd1);
    vectors++; if (bus.dout_valid !== 1'b1 || bus.dbg_cnt !== 4'd5) begin miscompares++; $display("FAIL rm_pre: got valid=%b cnt=%0d want 1/5", bus.dout_valid, bus.dbg_cnt); end
    #1 rst = 1'b0;
    #1;
    vectors++;
    if (bus.dout_valid !== 1'b0 || bus.data_out !== 8'h00 || bus.dout_bits !== 4'd0 ||
        bus.busy !== 1'b0 || bus.din_ready !== 1'b0 || bus.dbg_cnt !== 4'd0) begin
      miscompares++;
      $display("FAIL rm_async: got valid=%b data=%h bits=%0d busy=%b ready=%b cnt=%0d want all 0",
               bus.dout_valid, bus.data_out, bus.dout_bits, bus.busy, bus.din_ready, bus.dbg_cnt);
    end
    bit_q.delete();
    exp_q.delete();
    @(negedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    bus.dout_ready = 1'b1;
    send(4'hF, 3'd4);
    send(4'h0, 3'd4);
    tick(1);
    vectors++; if (bus.data_out !== 8'hF0 || bus.dout_bits !== 4'd8) begin miscompares++; $display("FAIL rm_clean: got data=%h bits=%0d want f0/8", bus.data_out, bus.dout_bits); end
    tick(1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      bus.din_valid  = ($urandom_range(0, 3) != 0);
      bus.code_in    = 4'($urandom);
      bus.len_in     = 3'($urandom_range(0, 7));
      bus.flush      = ($urandom_range(0, 19) == 0);
      bus.dout_ready = ($urandom_range(0, 3) != 0);
      tick(1);
    end
    bus.din_valid  = 1'b0;
    bus.flush      = 1'b0;
    bus.dout_ready = 1'b1;
    tick(4);
    pulse_flush();
    tick(20);
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL rnd_leftover: got %0d words pending, want 0", exp_q.size()); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rnd_busy: got %b want 0", bus.busy); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    vectors        = 0;
    miscompares    = 0;
    bus.code_in    = '0;
    bus.len_in     = '0;
    bus.din_valid  = 1'b0;
    bus.flush      = 1'b0;
    bus.dout_ready = 1'b1;
    test_reset();
    test_exact_fill();
    test_straddle_flush();
    test_backpressure();
    test_flush_empty();
    test_len_edges();
    test_reset_mid();
    test_random();
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL end_queue: got %0d words pending, want 0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
